// File: rtl/d_jb_pkg.sv
// Shared encodings for the decode-stage jump/branch predictor: MIPS opcodes,
// control output encodings and the resolution FSM states.
package d_jb_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] FN_JR     = 6'b001000;

    typedef enum logic [2:0] {
        BOP_NONE = 3'b000,
        BOP_BEQ  = 3'b001,
        BOP_BNE  = 3'b010,
        BOP_BLEZ = 3'b011,
        BOP_BGTZ = 3'b100,
        BOP_BLTZ = 3'b101,
        BOP_BGEZ = 3'b110
    } bop_e;

    typedef enum logic [1:0] {
        JMP_NONE = 2'b00,
        JMP_J    = 2'b01,
        JMP_JR   = 2'b10
    } jump_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        PENDING  = 2'b01,
        REDIRECT = 2'b10
    } state_e;

endpackage

// File: rtl/d_jb_predict_ctrl_bht.sv
// Table of saturating direction counters: combinational lookup, one
// synchronous train port, every entry reset to weakly not-taken.
module d_jb_bht #(
    parameter int DEPTH = 64,
    parameter int CTR_W = 2,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [CTR_W-1:0] o_rd_ctr,
    input  logic             i_upd_en,
    input  logic [IDX_W-1:0] i_upd_idx,
    input  logic             i_upd_taken
);

    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;

    logic [DEPTH-1:0][CTR_W-1:0] ctr_q, ctr_d;
    logic [CTR_W-1:0]            cur;

    // Lookup sees the pre-update value when the same entry is trained.
    assign o_rd_ctr = ctr_q[i_rd_idx];

    always_comb begin
        ctr_d = ctr_q;
        cur   = ctr_q[i_upd_idx];
        if (i_upd_en) begin
            if (i_upd_taken && cur != CTR_MAX)
                ctr_d[i_upd_idx] = cur + 1'b1;
            else if (!i_upd_taken && cur != '0)
                ctr_d[i_upd_idx] = cur - 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) ctr_q <= {DEPTH{CTR_INIT}};
        else       ctr_q <= ctr_d;
    end

endmodule

// File: rtl/d_jb_predict_ctrl.sv
// Decode-stage jump/branch control: decoder, target adder, direction predictor
// and the single-outstanding-branch resolution FSM with mispredict redirect.
module d_jb_predict_ctrl
    import d_jb_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CTR_W     = 2,
    parameter int CNT_W     = 16,
    parameter int EXT_BR    = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [5:0]       i_con_instru,
    input  logic [5:0]       i_con_func,
    input  logic             i_con_rt,
    input  logic             i_dec_valid,
    input  logic             i_stall,
    input  logic [PC_W-1:0]  i_pc,
    input  logic [15:0]      i_imm16,
    input  logic             i_res_valid,
    input  logic             i_res_taken,
    output logic [1:0]       o_con_jump,
    output logic [2:0]       o_con_bop,
    output logic             o_con_aluPC4,
    output logic             o_pred_taken,
    output logic [PC_W-1:0]  o_pred_target,
    output logic             o_stall_req,
    output logic             o_flush,
    output logic [PC_W-1:0]  o_redirect_pc,
    output logic [CNT_W-1:0] o_mispred_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    jump_e            jump;
    bop_e             bop;
    logic             is_cond;
    logic [IDX_W-1:0] rd_idx;
    logic [CTR_W-1:0] rd_ctr;
    logic             pred_raw;
    logic [PC_W-1:0]  pc4, br_off;
    logic             upd_en;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pred_q, pred_d;
    logic [PC_W-1:0]  fallback_q, fallback_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    always_comb begin
        jump         = JMP_NONE;
        bop          = BOP_NONE;
        o_con_aluPC4 = 1'b0;
        case (i_con_instru)
            OP_RTYPE:  if (i_con_func == FN_JR) jump = JMP_JR;
            OP_J:      jump = JMP_J;
            OP_JAL: begin
                jump         = JMP_J;
                o_con_aluPC4 = 1'b1;
            end
            OP_BEQ:    bop = BOP_BEQ;
            OP_BNE:    bop = BOP_BNE;
            OP_BLEZ:   if (EXT_BR != 0) bop = BOP_BLEZ;
            OP_BGTZ:   if (EXT_BR != 0) bop = BOP_BGTZ;
            OP_REGIMM: if (EXT_BR != 0) bop = i_con_rt ? BOP_BGEZ : BOP_BLTZ;
            default: ;
        endcase
    end

    assign o_con_jump    = jump;
    assign o_con_bop     = bop;
    assign is_cond       = (bop != BOP_NONE);
    assign rd_idx        = i_pc[IDX_W+1:2];
    assign pred_raw      = rd_ctr[CTR_W-1];
    assign pc4           = i_pc + PC_W'(4);
    assign br_off        = {{(PC_W-18){i_imm16[15]}}, i_imm16, 2'b00};
    assign o_pred_target = pc4 + br_off;
    assign o_mispred_cnt = mispred_cnt_q;

    d_jb_bht #(
        .DEPTH (BHT_DEPTH),
        .CTR_W (CTR_W),
        .IDX_W (IDX_W)
    ) u_bht (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rd_idx    (rd_idx),
        .o_rd_ctr    (rd_ctr),
        .i_upd_en    (upd_en),
        .i_upd_idx   (idx_q),
        .i_upd_taken (i_res_taken)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        pred_d        = pred_q;
        fallback_d    = fallback_q;
        mispred_cnt_d = mispred_cnt_q;
        upd_en        = 1'b0;
        o_stall_req   = 1'b0;
        o_pred_taken  = pred_raw & is_cond;
        o_flush       = 1'b0;
        o_redirect_pc = '0;
        case (state_q)
            IDLE: begin
                if (i_dec_valid && is_cond && !i_stall) begin
                    state_d    = PENDING;
                    idx_d      = rd_idx;
                    pred_d     = pred_raw;
                    // Keep the path we did not predict, for use on mispredict.
                    fallback_d = pred_raw ? pc4 : o_pred_target;
                end
            end
            PENDING: begin
                o_stall_req = i_dec_valid & is_cond;
                if (i_res_valid) begin
                    upd_en = 1'b1;
                    if (i_res_taken == pred_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = REDIRECT;
                        if (mispred_cnt_q != '1) mispred_cnt_d = mispred_cnt_q + 1'b1;
                    end
                end
            end
            REDIRECT: begin
                o_flush       = 1'b1;
                o_redirect_pc = fallback_q;
                o_pred_taken  = 1'b0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            pred_q        <= 1'b0;
            fallback_q    <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            pred_q        <= pred_d;
            fallback_q    <= fallback_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

endmodule

// File: tb/tb_d_jb_predict_ctrl.sv
// Directed bench for d_jb_predict_ctrl: decode, training, redirect, stall and reset.
module tb_d_jb_predict_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [5:0]  i_con_instru, i_con_func;
    logic        i_con_rt, i_dec_valid, i_stall;
    logic [31:0] i_pc;
    logic [15:0] i_imm16;
    logic        i_res_valid, i_res_taken;

    logic [1:0]  o_con_jump, z_con_jump;
    logic [2:0]  o_con_bop, z_con_bop;
    logic        o_con_aluPC4, z_con_aluPC4, o_pred_taken, z_pred_taken;
    logic [31:0] o_pred_target, z_pred_target, o_redirect_pc, z_redirect_pc;
    logic        o_stall_req, z_stall_req, o_flush, z_flush;
    logic [15:0] o_mispred_cnt, z_mispred_cnt;

    int checks = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    d_jb_predict_ctrl #(.EXT_BR(1)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_con_instru(i_con_instru), .i_con_func(i_con_func),
        .i_con_rt(i_con_rt), .i_dec_valid(i_dec_valid), .i_stall(i_stall), .i_pc(i_pc),
        .i_imm16(i_imm16), .i_res_valid(i_res_valid), .i_res_taken(i_res_taken),
        .o_con_jump(o_con_jump), .o_con_bop(o_con_bop), .o_con_aluPC4(o_con_aluPC4),
        .o_pred_taken(o_pred_taken), .o_pred_target(o_pred_target), .o_stall_req(o_stall_req),
        .o_flush(o_flush), .o_redirect_pc(o_redirect_pc), .o_mispred_cnt(o_mispred_cnt)
    );

    d_jb_predict_ctrl #(.EXT_BR(0)) dut0 (
        .i_clk(i_clk), .i_rst(i_rst), .i_con_instru(i_con_instru), .i_con_func(i_con_func),
        .i_con_rt(i_con_rt), .i_dec_valid(i_dec_valid), .i_stall(i_stall), .i_pc(i_pc),
        .i_imm16(i_imm16), .i_res_valid(i_res_valid), .i_res_taken(i_res_taken),
        .o_con_jump(z_con_jump), .o_con_bop(z_con_bop), .o_con_aluPC4(z_con_aluPC4),
        .o_pred_taken(z_pred_taken), .o_pred_target(z_pred_target), .o_stall_req(z_stall_req),
        .o_flush(z_flush), .o_redirect_pc(z_redirect_pc), .o_mispred_cnt(z_mispred_cnt)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_in();
        i_con_instru = '0; i_con_func = '0; i_con_rt = 1'b0; i_dec_valid = 1'b0;
        i_stall = 1'b0; i_pc = '0; i_imm16 = '0; i_res_valid = 1'b0; i_res_taken = 1'b0;
    endtask

    task automatic set_br(input logic [5:0] op, input logic [31:0] pc, input logic [15:0] imm);
        i_con_instru = op; i_pc = pc; i_imm16 = imm; i_con_func = '0; i_con_rt = 1'b0;
    endtask

    task automatic test_reset();
        clear_in();
        #1 i_rst = 1'b1;
        tick(); tick();
        checks++; if (o_flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%0b exp=0", o_flush); end
        checks++; if (o_redirect_pc !== 32'h0) begin failures++; $display("FAIL reset_redirect got=%0h exp=0", o_redirect_pc); end
        checks++; if (o_mispred_cnt !== 16'h0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", o_mispred_cnt); end
        i_rst = 1'b0;
        tick();
    endtask

    task automatic test_decode_beq();
        set_br(6'b000100, 32'h100, 16'd4);
        #1;
        checks++; if (o_con_bop !== 3'b001) begin failures++; $display("FAIL beq_bop got=%0b exp=001", o_con_bop); end
        checks++; if (o_pred_taken !== 1'b0) begin failures++; $display("FAIL beq_pred got=%0b exp=0", o_pred_taken); end
        checks++; if (o_pred_target !== 32'h114) begin failures++; $display("FAIL beq_target got=%0h exp=114", o_pred_target); end
        checks++; if (o_con_jump !== 2'b00) begin failures++; $display("FAIL beq_jump got=%0b exp=00", o_con_jump); end
    endtask

    // One beq at 0x100 (imm 4) through decode and resolution; returns to IDLE side.
    task automatic run_beq(input logic taken, input logic exp_pred, input logic exp_flush,
                           input logic [31:0] exp_redir, input logic [15:0] exp_cnt);
        set_br(6'b000100, 32'h100, 16'd4);
        i_dec_valid = 1'b1;
        #1;
        checks++; if (o_pred_taken !== exp_pred) begin failures++; $display("FAIL train_pred got=%0b exp=%0b", o_pred_taken, exp_pred); end
        tick();
        i_dec_valid = 1'b0; i_res_valid = 1'b1; i_res_taken = taken;
        tick();
        i_res_valid = 1'b0;
        #1;
        checks++; if (o_flush !== exp_flush) begin failures++; $display("FAIL train_flush got=%0b exp=%0b", o_flush, exp_flush); end
        checks++; if (o_redirect_pc !== exp_redir) begin failures++; $display("FAIL train_redirect got=%0h exp=%0h", o_redirect_pc, exp_redir); end
        checks++; if (o_mispred_cnt !== exp_cnt) begin failures++; $display("FAIL train_cnt got=%0d exp=%0d", o_mispred_cnt, exp_cnt); end
        if (exp_flush) begin
            tick();
            checks++; if (o_flush !== 1'b0) begin failures++; $display("FAIL flush_one_cycle got=%0b exp=0", o_flush); end
        end
    endtask

    task automatic test_train();
        run_beq(1'b1, 1'b0, 1'b1, 32'h114, 16'd1); // 01 -> 10, mispredict
        run_beq(1'b1, 1'b1, 1'b0, 32'h0,   16'd1); // 10 -> 11
        run_beq(1'b1, 1'b1, 1'b0, 32'h0,   16'd1); // 11 stays 11
        run_beq(1'b0, 1'b1, 1'b1, 32'h104, 16'd2); // 11 -> 10, mispredict
        run_beq(1'b0, 1'b1, 1'b1, 32'h104, 16'd3); // 10 -> 01, mispredict
        set_br(6'b000100, 32'h100, 16'd4);
        #1;
        checks++; if (o_pred_taken !== 1'b0) begin failures++; $display("FAIL train_final_pred got=%0b exp=0", o_pred_taken); end
    endtask

    task automatic test_back_to_back();
        set_br(6'b000100, 32'h208, 16'd4);
        i_dec_valid = 1'b1;
        tick();
        set_br(6'b000101, 32'h30C, 16'hFFFE);
        i_res_valid = 1'b1; i_res_taken = 1'b0;
        #1;
        checks++; if (o_stall_req !== 1'b1) begin failures++; $display("FAIL pend_stall got=%0b exp=1", o_stall_req); end
        checks++; if (o_pred_target !== 32'h308) begin failures++; $display("FAIL bne_target got=%0h exp=308", o_pred_target); end
        tick();
        i_res_valid = 1'b0;
        #1;
        checks++; if (o_flush !== 1'b0) begin failures++; $display("FAIL correct_flush got=%0b exp=0", o_flush); end
        checks++; if (o_stall_req !== 1'b0) begin failures++; $display("FAIL idle_stall got=%0b exp=0", o_stall_req); end
        tick();
        i_con_instru = 6'b000010;
        #1;
        checks++; if (o_con_jump !== 2'b01 || o_stall_req !== 1'b0) begin failures++; $display("FAIL pend_jump got=%0b/%0b exp=01/0", o_con_jump, o_stall_req); end
        set_br(6'b000100, 32'h208, 16'd4);
        #1;
        checks++; if (o_stall_req !== 1'b1) begin failures++; $display("FAIL bne_pending got=%0b exp=1", o_stall_req); end
        i_res_valid = 1'b1; i_res_taken = 1'b1;
        tick();
        checks++; if (o_flush !== 1'b1 || o_redirect_pc !== 32'h308) begin failures++; $display("FAIL bne_redirect got=%0b/%0h exp=1/308", o_flush, o_redirect_pc); end
        checks++; if (o_mispred_cnt !== 16'd4) begin failures++; $display("FAIL bne_cnt got=%0d exp=4", o_mispred_cnt); end
        checks++; if (o_stall_req !== 1'b0 || o_pred_taken !== 1'b0) begin failures++; $display("FAIL redir_stall_pred got=%0b/%0b exp=0/0", o_stall_req, o_pred_taken); end
        tick();
        i_stall = 1'b1;
        tick();
        checks++; if (o_flush !== 1'b0) begin failures++; $display("FAIL idle_res_ignored got=%0b exp=0", o_flush); end
        clear_in();
        tick();
    endtask

    task automatic test_ext_br();
        i_con_instru = 6'b000110; #1;
        checks++; if ({z_con_jump, z_con_bop, z_con_aluPC4, z_pred_taken} !== 7'd0) begin failures++; $display("FAIL ext0_blez got=%0h exp=0", {z_con_jump, z_con_bop, z_con_aluPC4, z_pred_taken}); end
        checks++; if (o_con_bop !== 3'b011) begin failures++; $display("FAIL ext1_blez got=%0b exp=011", o_con_bop); end
        i_con_instru = 6'b000111; #1;
        checks++; if (o_con_bop !== 3'b100) begin failures++; $display("FAIL ext1_bgtz got=%0b exp=100", o_con_bop); end
        i_con_instru = 6'b000001; i_con_rt = 1'b1; #1;
        checks++; if (o_con_bop !== 3'b110 || z_con_bop !== 3'b000) begin failures++; $display("FAIL bgez got=%0b/%0b exp=110/000", o_con_bop, z_con_bop); end
        i_con_rt = 1'b0; #1;
        checks++; if (o_con_bop !== 3'b101) begin failures++; $display("FAIL bltz got=%0b exp=101", o_con_bop); end
        i_con_instru = 6'b000000; i_con_func = 6'b001000; #1;
        checks++; if (o_con_jump !== 2'b10 || o_con_bop !== 3'b000) begin failures++; $display("FAIL jr got=%0b/%0b exp=10/000", o_con_jump, o_con_bop); end
        i_con_func = 6'b001001; #1;
        checks++; if (o_con_jump !== 2'b00) begin failures++; $display("FAIL non_jr got=%0b exp=00", o_con_jump); end
        clear_in();
    endtask

    task automatic test_async_reset();
        set_br(6'b000100, 32'h100, 16'd4);
        i_dec_valid = 1'b1;
        tick();
        i_dec_valid = 1'b0; i_res_valid = 1'b1; i_res_taken = 1'b1;
        #2 i_rst = 1'b1;
        #1;
        checks++; if (o_flush !== 1'b0) begin failures++; $display("FAIL rst_mid_flush got=%0b exp=0", o_flush); end
        tick();
        checks++; if (o_flush !== 1'b0 || o_mispred_cnt !== 16'd0) begin failures++; $display("FAIL rst_hold got=%0b/%0d exp=0/0", o_flush, o_mispred_cnt); end
        i_res_valid = 1'b0;
        i_rst = 1'b0;
        tick();
        checks++; if (o_flush !== 1'b0) begin failures++; $display("FAIL rst_after_flush got=%0b exp=0", o_flush); end
        set_br(6'b000101, 32'h30C, 16'd0);
        #1;
        checks++; if (o_pred_taken !== 1'b0) begin failures++; $display("FAIL rst_table_init got=%0b exp=0", o_pred_taken); end
        i_con_instru = 6'b000011;
        #1;
        checks++; if (o_con_jump !== 2'b01 || o_con_aluPC4 !== 1'b1) begin failures++; $display("FAIL jal got=%0b/%0b exp=01/1", o_con_jump, o_con_aluPC4); end
        clear_in();
    endtask

    initial begin
        test_reset();
        test_decode_beq();
        test_train();
        test_back_to_back();
        test_ext_br();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
